// File: rtl/gpio_pin_filter.sv
// Pad input conditioning for the GPIO block: 2-flop synchroniser, per-pin
// tick-timed debounce filter, and registered single-cycle rise/fall pulses.
module gpio_pin_filter #(
  parameter int PIN_W = 16,
  parameter int CNT_W = 8,
  parameter int PRE_W = 16
) (
  input  logic             pclk,
  input  logic             p_reset,
  input  logic [PIN_W-1:0] pad_in,
  input  logic [PIN_W-1:0] filter_en,
  input  logic [PRE_W-1:0] prescale,
  input  logic [CNT_W-1:0] threshold,
  output logic [PIN_W-1:0] pin_filt,
  output logic [PIN_W-1:0] rise_pulse,
  output logic [PIN_W-1:0] fall_pulse,
  output logic             sample_tick
);

  logic [PIN_W-1:0] sync1_q, sync2_q;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] cnt_q [PIN_W];
  logic [CNT_W-1:0] cnt_d [PIN_W];
  logic [PIN_W-1:0] filt_q, filt_d;
  logic [PIN_W-1:0] rise_q, rise_d;
  logic [PIN_W-1:0] fall_q, fall_d;
  logic [CNT_W-1:0] thr_eff;

  always_comb begin
    // ">=" also catches a count left above a freshly lowered prescale.
    pre_cnt_d = (pre_cnt_q >= prescale) ? '0 : pre_cnt_q + PRE_W'(1);
    tick_d    = (pre_cnt_d == prescale);
    thr_eff   = (threshold == '0) ? CNT_W'(1) : threshold;
    filt_d    = filt_q;
    for (int i = 0; i < PIN_W; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!filter_en[i]) begin
        filt_d[i] = sync2_q[i];
        cnt_d[i]  = '0;
      end else if (tick_q) begin
        if (sync2_q[i] == filt_q[i]) begin
          cnt_d[i] = '0;
        end else if (({1'b0, cnt_q[i]} + (CNT_W+1)'(1)) >= {1'b0, thr_eff}) begin
          filt_d[i] = sync2_q[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    rise_d = filt_d & ~filt_q;
    fall_d = ~filt_d & filt_q;
  end

  always_ff @(posedge pclk) begin
    if (p_reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      pre_cnt_q <= '0;
      tick_q    <= 1'b0;
      filt_q    <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      for (int i = 0; i < PIN_W; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= pad_in;
      sync2_q   <= sync1_q;
      pre_cnt_q <= pre_cnt_d;
      tick_q    <= tick_d;
      filt_q    <= filt_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      for (int i = 0; i < PIN_W; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign pin_filt    = filt_q;
  assign rise_pulse  = rise_q;
  assign fall_pulse  = fall_q;
  assign sample_tick = tick_q;

endmodule

// File: tb/tb_gpio_pin_filter.sv
// Directed bench for gpio_pin_filter: bypass latency, debounce, glitch
// rejection, prescaler timing, threshold/enable changes and mid-run reset.
module tb_gpio_pin_filter;

  logic        pclk = 1'b0;
  logic        p_reset;
  logic [15:0] pad_in, filter_en, prescale;
  logic [7:0]  threshold;
  logic [15:0] pin_filt, rise_pulse, fall_pulse;
  logic        sample_tick;

  int n_cmp = 0;
  int n_bad = 0;

  gpio_pin_filter dut (
    .pclk(pclk), .p_reset(p_reset), .pad_in(pad_in), .filter_en(filter_en),
    .prescale(prescale), .threshold(threshold), .pin_filt(pin_filt),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .sample_tick(sample_tick)
  );

  always #5 pclk = ~pclk;

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic step(input int n = 1);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic test_reset;
    p_reset = 1'b1; pad_in = 16'h0000; filter_en = 16'h0000;
    prescale = 16'd0; threshold = 8'd1;
    step(2);
    n_cmp++;
    if ({pin_filt, rise_pulse, fall_pulse, sample_tick} !== 49'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got filt=%h rise=%h fall=%h tick=%b want all 0",
               pin_filt, rise_pulse, fall_pulse, sample_tick);
    end
    p_reset = 1'b0;
    step(3);
  endtask

  task automatic test_bypass;
    pad_in = 16'hA5A5;
    step(2);
    n_cmp++;
    if (pin_filt !== 16'h0000) begin
      n_bad++; $display("FAIL bypass_edge2: got %h want 0000", pin_filt);
    end
    step();
    n_cmp++;
    if (pin_filt !== 16'hA5A5 || rise_pulse !== 16'hA5A5 || fall_pulse !== 16'h0000) begin
      n_bad++;
      $display("FAIL bypass_edge3: got filt=%h rise=%h fall=%h want A5A5/A5A5/0000",
               pin_filt, rise_pulse, fall_pulse);
    end
    step();
    n_cmp++;
    if (pin_filt !== 16'hA5A5 || rise_pulse !== 16'h0000) begin
      n_bad++; $display("FAIL bypass_pulse_width: got filt=%h rise=%h want A5A5/0000", pin_filt, rise_pulse);
    end
    pad_in = 16'h0000;
    step(3);
    n_cmp++;
    if (pin_filt !== 16'h0000 || fall_pulse !== 16'hA5A5 || rise_pulse !== 16'h0000) begin
      n_bad++;
      $display("FAIL bypass_fall: got filt=%h rise=%h fall=%h want 0000/0000/A5A5",
               pin_filt, rise_pulse, fall_pulse);
    end
    step(2);
  endtask

  task automatic test_debounce;
    logic [15:0] rise_or;
    filter_en = 16'hFFFF; prescale = 16'd0; threshold = 8'd4;
    step(2);
    pad_in = 16'h0001;
    step(5);
    n_cmp++;
    if (pin_filt !== 16'h0000) begin
      n_bad++; $display("FAIL debounce_early: got %h want 0000", pin_filt);
    end
    step();
    n_cmp++;
    if (pin_filt !== 16'h0001 || rise_pulse !== 16'h0001) begin
      n_bad++; $display("FAIL debounce_accept: got filt=%h rise=%h want 0001/0001", pin_filt, rise_pulse);
    end
    rise_or = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      rise_or |= rise_pulse;
    end
    n_cmp++;
    if (rise_or !== 16'h0000 || pin_filt !== 16'h0001) begin
      n_bad++; $display("FAIL debounce_single_pulse: got extra rise=%h filt=%h want 0000/0001", rise_or, pin_filt);
    end
  endtask

  task automatic test_glitch;
    logic [15:0] pulse_or;
    logic [15:0] filt_or;
    pulse_or = '0; filt_or = '0;
    pad_in = 16'h0009;
    step(3);
    pad_in = 16'h0001;
    for (int k = 4; k <= 10; k++) begin
      step();
      pulse_or |= rise_pulse | fall_pulse;
      filt_or  |= pin_filt;
      if (k == 5) begin
        n_cmp++;
        if (dut.cnt_q[3] !== 8'd3) begin
          n_bad++; $display("FAIL glitch_cnt_peak: got %0d want 3", dut.cnt_q[3]);
        end
      end
    end
    n_cmp++;
    if (pulse_or !== 16'h0000 || filt_or !== 16'h0001) begin
      n_bad++; $display("FAIL glitch_reject: got pulses=%h filt_or=%h want 0000/0001", pulse_or, filt_or);
    end
    n_cmp++;
    if (dut.cnt_q[3] !== 8'd0) begin
      n_bad++; $display("FAIL glitch_cnt_clear: got %0d want 0", dut.cnt_q[3]);
    end
  endtask

  task automatic test_prescaler;
    int found, period, ticks, fall_at, falls;
    pad_in = 16'h0081; filter_en = 16'hFF7F;
    step(4);
    filter_en = 16'hFFFF; prescale = 16'd9; threshold = 8'd2;
    n_cmp++;
    if (pin_filt !== 16'h0081) begin
      n_bad++; $display("FAIL presc_setup: got %h want 0081", pin_filt);
    end
    found = 0;
    for (int k = 0; k < 30 && found == 0; k++) begin
      step();
      if (sample_tick === 1'b1) found = 1;
    end
    period = 0;
    for (int k = 1; k <= 15 && period == 0; k++) begin
      step();
      if (sample_tick === 1'b1) period = k;
    end
    n_cmp++;
    if (found == 0 || period != 10) begin
      n_bad++; $display("FAIL presc_period: got found=%0d period=%0d want 1/10", found, period);
    end
    pad_in = 16'h0001;
    ticks = 0; fall_at = 0; falls = 0;
    for (int k = 1; k <= 25; k++) begin
      step();
      if (sample_tick === 1'b1 && k <= 21) ticks++;
      if (fall_pulse !== 16'h0000) begin
        falls++;
        if (fall_pulse !== 16'h0080) fall_at = -1;
      end
      if (pin_filt[7] === 1'b0 && fall_at == 0) fall_at = k;
    end
    n_cmp++;
    if (fall_at != 21 || falls != 1) begin
      n_bad++; $display("FAIL presc_fall: got fall_at=%0d pulses=%0d want 21/1", fall_at, falls);
    end
    n_cmp++;
    if (ticks != 2) begin
      n_bad++; $display("FAIL presc_tick_count: got %0d want 2", ticks);
    end
    prescale = 16'd0;
    step(3);
  endtask

  task automatic test_threshold;
    threshold = 8'd0;
    pad_in = 16'h0021;
    step(2);
    n_cmp++;
    if (pin_filt !== 16'h0001) begin
      n_bad++; $display("FAIL thr0_early: got %h want 0001", pin_filt);
    end
    step();
    n_cmp++;
    if (pin_filt !== 16'h0021 || rise_pulse !== 16'h0020) begin
      n_bad++; $display("FAIL thr0_accept: got filt=%h rise=%h want 0021/0020", pin_filt, rise_pulse);
    end
    step(2);
    threshold = 8'd8;
    pad_in = 16'h0061;
    step(7);
    n_cmp++;
    if (dut.cnt_q[6] !== 8'd5 || pin_filt !== 16'h0021) begin
      n_bad++; $display("FAIL thr_midcount: got cnt=%0d filt=%h want 5/0021", dut.cnt_q[6], pin_filt);
    end
    threshold = 8'd3;
    step();
    n_cmp++;
    if (pin_filt !== 16'h0061 || rise_pulse !== 16'h0040) begin
      n_bad++; $display("FAIL thr_lowered: got filt=%h rise=%h want 0061/0040", pin_filt, rise_pulse);
    end
    step(2);
    threshold = 8'd8;
    pad_in = 16'h0065;
    step(5);
    n_cmp++;
    if (dut.cnt_q[2] !== 8'd3 || pin_filt !== 16'h0061) begin
      n_bad++; $display("FAIL en_midcount: got cnt=%0d filt=%h want 3/0061", dut.cnt_q[2], pin_filt);
    end
    filter_en = 16'hFFFB;
    step();
    n_cmp++;
    if (pin_filt !== 16'h0065 || rise_pulse !== 16'h0004 || dut.cnt_q[2] !== 8'd0) begin
      n_bad++;
      $display("FAIL en_cleared: got filt=%h rise=%h cnt=%0d want 0065/0004/0",
               pin_filt, rise_pulse, dut.cnt_q[2]);
    end
    step(2);
  endtask

  task automatic test_reset_mid;
    pad_in = 16'h0263;
    step(3);
    n_cmp++;
    if (fall_pulse !== 16'h0004 || dut.cnt_q[9] !== 8'd1) begin
      n_bad++; $display("FAIL rstmid_pre: got fall=%h cnt9=%0d want 0004/1", fall_pulse, dut.cnt_q[9]);
    end
    p_reset = 1'b1;
    step();
    n_cmp++;
    if ({pin_filt, rise_pulse, fall_pulse, sample_tick} !== 49'd0 || dut.cnt_q[9] !== 8'd0) begin
      n_bad++;
      $display("FAIL rstmid_clear: got filt=%h rise=%h fall=%h tick=%b cnt9=%0d want all 0",
               pin_filt, rise_pulse, fall_pulse, sample_tick, dut.cnt_q[9]);
    end
    p_reset = 1'b0;
    step(3);
    n_cmp++;
    if (pin_filt !== 16'h0000 || dut.cnt_q[9] !== 8'd1) begin
      n_bad++; $display("FAIL rstmid_restart: got filt=%h cnt9=%0d want 0000/1", pin_filt, dut.cnt_q[9]);
    end
    threshold = 8'd1;
    step();
    n_cmp++;
    if (pin_filt !== 16'h0263 || rise_pulse !== 16'h0263 || fall_pulse !== 16'h0000) begin
      n_bad++;
      $display("FAIL rstmid_accept: got filt=%h rise=%h fall=%h want 0263/0263/0000",
               pin_filt, rise_pulse, fall_pulse);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_bypass();
    test_debounce();
    test_glitch();
    test_prescaler();
    test_threshold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
